// File: rtl/wb_mcu_bram_arbiter.sv
// Two-master Wishbone arbiter for the FPGA-side port of the MCU shared BRAM.
// Accesses are serialised through IDLE -> ACCESS -> ACK, which covers the
// BRAM's one-cycle synchronous read latency. Round-robin arbitration by
// default; FIXED_PRIO=1 makes m0 win every tie.
//
// Handshake: a master requests with cyc&stb held high and keeps its request
// until it sees ack. Ack is a single-cycle pulse in ACK, and read data is
// valid only while ack is high. Dropping the request early aborts the ack,
// but the slave access still completes.
module wb_mcu_bram_arbiter #(
   parameter int FIXED_PRIO = 0,
   parameter int ADR_W      = 10,
   parameter int DAT_W      = 16,
   parameter int SEL_W      = DAT_W / 8
) (
   input  logic             clk_i,
   input  logic             resetn,
   // master 0
   input  logic             m0_wb_cyc_i,
   input  logic             m0_wb_stb_i,
   input  logic             m0_wb_we_i,
   input  logic [ADR_W-1:0] m0_wb_adr_i,
   input  logic [DAT_W-1:0] m0_wb_dat_i,
   input  logic [SEL_W-1:0] m0_wb_sel_i,
   output logic [DAT_W-1:0] m0_wb_dat_o,
   output logic             m0_wb_ack_o,
   // master 1
   input  logic             m1_wb_cyc_i,
   input  logic             m1_wb_stb_i,
   input  logic             m1_wb_we_i,
   input  logic [ADR_W-1:0] m1_wb_adr_i,
   input  logic [DAT_W-1:0] m1_wb_dat_i,
   input  logic [SEL_W-1:0] m1_wb_sel_i,
   output logic [DAT_W-1:0] m1_wb_dat_o,
   output logic             m1_wb_ack_o,
   // BRAM port
   output logic             wb_cyc_o,
   output logic             wb_stb_o,
   output logic             wb_we_o,
   output logic [ADR_W-1:0] wb_adr_o,
   output logic [DAT_W-1:0] wb_dat_o,
   output logic [SEL_W-1:0] wb_sel_o,
   input  logic [DAT_W-1:0] wb_dat_i,
   // debug: current FSM state (0 IDLE, 1 ACCESS, 2 ACK)
   output logic [1:0]       fsm_state_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_ACK    = 2'd2
   } state_t;

   state_t state;
   logic   owner;       // 0: m0 owns the current access, 1: m1
   logic   last_grant;  // master granted most recently
   logic   m0_req;
   logic   m1_req;
   logic   grant_m1;
   logic   ack0;
   logic   ack1;

   // Request decode and arbitration; m1 wins only when m0 is absent or,
   // in round-robin mode, when m0 was the last master served.
   always_comb begin
      m0_req   = m0_wb_cyc_i & m0_wb_stb_i;
      m1_req   = m1_wb_cyc_i & m1_wb_stb_i;
      grant_m1 = m1_req & (~m0_req | ((FIXED_PRIO == 0) & ~last_grant));
   end

   // Sequencer: grants and latches the request in IDLE, strobes the BRAM for
   // exactly one cycle in ACCESS, then spends one cycle in ACK.
   always_ff @(posedge clk_i or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         wb_cyc_o   <= 1'b0;
         wb_stb_o   <= 1'b0;
         wb_we_o    <= 1'b0;
         wb_adr_o   <= '0;
         wb_dat_o   <= '0;
         wb_sel_o   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (m0_req | m1_req) begin
                  owner      <= grant_m1;
                  last_grant <= grant_m1;
                  wb_cyc_o   <= 1'b1;
                  wb_stb_o   <= 1'b1;
                  wb_we_o    <= grant_m1 ? m1_wb_we_i  : m0_wb_we_i;
                  wb_adr_o   <= grant_m1 ? m1_wb_adr_i : m0_wb_adr_i;
                  wb_dat_o   <= grant_m1 ? m1_wb_dat_i : m0_wb_dat_i;
                  wb_sel_o   <= grant_m1 ? m1_wb_sel_i : m0_wb_sel_i;
                  state      <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               // The access completes regardless of the owner's request.
               wb_cyc_o <= 1'b0;
               wb_stb_o <= 1'b0;
               wb_we_o  <= 1'b0;
               state    <= S_ACK;
            end
            S_ACK: begin
               state <= S_IDLE;
            end
            default: begin
               wb_cyc_o <= 1'b0;
               wb_stb_o <= 1'b0;
               wb_we_o  <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

   // Ack and read-data return: only the owner, only in ACK, only while it
   // still requests; BRAM data passes straight through with no register.
   always_comb begin
      ack0        = (state == S_ACK) & ~owner & m0_req;
      ack1        = (state == S_ACK) &  owner & m1_req;
      m0_wb_ack_o = ack0;
      m1_wb_ack_o = ack1;
      m0_wb_dat_o = ack0 ? wb_dat_i : '0;
      m1_wb_dat_o = ack1 ? wb_dat_i : '0;
      fsm_state_o = state;
   end

endmodule
